// File: rtl/l1_cache_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | l1_cache_if : CPU load/store port and L2 block port of the L1 cache   |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
interface l1_cache_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 32
);
    logic [ADDR_WIDTH-1:0]            cpu_addr;
    logic [DATA_WIDTH-1:0]            cpu_wdata;
    logic                             cpu_read;
    logic                             cpu_write;
    logic [DATA_WIDTH-1:0]            cpu_rdata;
    logic                             cpu_ready;
    logic                             cpu_hit;
    logic [ADDR_WIDTH-1:0]            l2_addr;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out;
    logic                             l2_read;
    logic                             l2_write;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_in;
    logic                             l2_block_valid;
    logic                             l2_ready;

    // Cache side
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
        input  l2_block_in, l2_block_valid, l2_ready,
        output cpu_rdata, cpu_ready, cpu_hit,
        output l2_addr, l2_data_out, l2_read, l2_write
    );

    // CPU plus L2 side
    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write,
        output l2_block_in, l2_block_valid, l2_ready,
        input  cpu_rdata, cpu_ready, cpu_hit,
        input  l2_addr, l2_data_out, l2_read, l2_write
    );
endinterface
`default_nettype wire

// File: rtl/l1_cache.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | l1_cache : direct-mapped, write-through, write-allocate L1 data cache |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module l1_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CACHE_SIZE = 128,
    parameter int BLOCK_SIZE = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    l1_cache_if.slave bus
);
    localparam int LINES    = CACHE_SIZE / BLOCK_SIZE;
    localparam int OFFSET_W = $clog2(BLOCK_SIZE);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int LINE_W   = BLOCK_SIZE * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        FILL   = 3'd2,
        WTHRU  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state;

    logic [LINE_W-1:0]     line_data [LINES];
    logic [TAG_W-1:0]      line_tag  [LINES];
    logic [LINES-1:0]      line_valid;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_write;
    logic                  hit_flag;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_index;
    logic [OFFSET_W-1:0]   req_offset;
    logic [ADDR_WIDTH-1:0] block_addr;
    logic                  lookup_hit;
    logic                  fill_done;
    logic [DATA_WIDTH-1:0] cached_word;
    logic [DATA_WIDTH-1:0] fill_word;
    logic [LINE_W-1:0]     merge_src;
    logic [LINE_W-1:0]     merged_line;

    assign req_tag     = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_index   = req_addr[OFFSET_W +: INDEX_W];
    assign req_offset  = req_addr[OFFSET_W-1:0];
    assign block_addr  = {req_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign lookup_hit  = line_valid[req_index] && (line_tag[req_index] == req_tag);
    assign fill_done   = bus.l2_ready && bus.l2_block_valid;
    assign cached_word = line_data[req_index][req_offset*DATA_WIDTH +: DATA_WIDTH];
    assign fill_word   = bus.l2_block_in[req_offset*DATA_WIDTH +: DATA_WIDTH];

    // Store data merged into either the resident line (write hit) or the fetched block (write miss)
    always_comb begin
        merge_src   = (state == FILL) ? bus.l2_block_in : line_data[req_index];
        merged_line = merge_src;
        merged_line[req_offset*DATA_WIDTH +: DATA_WIDTH] = req_wdata;
    end

    // Requests drop in the same cycle the registered L2 ready arrives
    assign bus.l2_read  = (state == FILL)  && !bus.l2_ready;
    assign bus.l2_write = (state == WTHRU) && !bus.l2_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            req_addr        <= '0;
            req_wdata       <= '0;
            req_write       <= 1'b0;
            hit_flag        <= 1'b0;
            line_valid      <= '0;
            bus.cpu_rdata   <= '0;
            bus.cpu_ready   <= 1'b0;
            bus.cpu_hit     <= 1'b0;
            bus.l2_addr     <= '0;
            bus.l2_data_out <= '0;
        end else begin
            bus.cpu_ready <= 1'b0;
            bus.cpu_hit   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_read || bus.cpu_write) begin
                        req_addr  <= bus.cpu_addr;
                        req_wdata <= bus.cpu_wdata;
                        req_write <= bus.cpu_write;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    bus.l2_addr <= block_addr;
                    if (lookup_hit) begin
                        hit_flag <= 1'b1;
                        if (req_write) begin
                            bus.l2_data_out <= merged_line;
                            state           <= WTHRU;
                        end else begin
                            bus.cpu_rdata <= cached_word;
                            bus.cpu_ready <= 1'b1;
                            bus.cpu_hit   <= 1'b1;
                            state         <= RESP;
                        end
                    end else begin
                        // Victim is always clean, so a miss simply refills the indexed line
                        hit_flag <= 1'b0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (fill_done) begin
                        line_valid[req_index] <= 1'b1;
                        if (req_write) begin
                            bus.l2_data_out <= merged_line;
                            state           <= WTHRU;
                        end else begin
                            bus.cpu_rdata <= fill_word;
                            bus.cpu_ready <= 1'b1;
                            bus.cpu_hit   <= hit_flag;
                            state         <= RESP;
                        end
                    end
                end
                WTHRU: begin
                    if (bus.l2_ready) begin
                        bus.cpu_ready <= 1'b1;
                        bus.cpu_hit   <= hit_flag;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line storage carries no reset; only the valid bits matter after reset
    always_ff @(posedge clk) begin
        if (state == LOOKUP && lookup_hit && req_write) begin
            line_data[req_index] <= merged_line;
        end
        if (state == FILL && fill_done) begin
            line_data[req_index] <= req_write ? merged_line : bus.l2_block_in;
            line_tag[req_index]  <= req_tag;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_l1_cache.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_l1_cache : randomized scoreboard bench with L2 and cache models    |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_l1_cache;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int BS = 32;
    localparam int LW = BS * DW;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        bit          hit;
    } cpu_exp_t;

    typedef struct {
        bit          wr;
        logic [10:0] addr;
    } l2_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

    l1_cache #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_SIZE(128), .BLOCK_SIZE(BS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    cpu_exp_t    sb  [$];
    l2_exp_t     l2q [$];
    logic [31:0] ref_mem [2048];
    logic [31:0] l2mem   [2048];
    int          resident [4];
    int          tests = 0;
    int          fails = 0;
    int          epoch = 0;

    // Issue one CPU access; expectations come from the block-residency model
    task automatic do_op(input bit wr, input logic [10:0] a, input logic [31:0] d);
        int       blk;
        int       idx;
        int       n;
        bit       hit;
        bit       seen;
        l2_exp_t  le;
        cpu_exp_t ce;
        blk = int'(a) / 32;
        idx = blk % 4;
        hit = (resident[idx] == blk);
        if (!hit) begin
            le.wr = 1'b0; le.addr = 11'(blk * 32);
            l2q.push_back(le);
        end
        if (wr) begin
            ref_mem[a] = d;
            le.wr = 1'b1; le.addr = 11'(blk * 32);
            l2q.push_back(le);
        end
        resident[idx] = blk;
        ce.wr = wr; ce.data = ref_mem[a]; ce.hit = hit;
        sb.push_back(ce);
        @(posedge clk); #1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_read  = !wr;
        bus.cpu_write = wr;
        n = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            seen = bus.cpu_ready;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL timeout addr=%h: no cpu_ready within %0d cycles, required a response", a, n);
        end else if (hit && !wr) begin
            tests++;
            if (n != 3) begin
                fails++;
                $display("FAIL hit_latency addr=%h: got %0d, required 3", a, n);
            end
        end
        @(posedge clk); #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    initial begin : l2_model
        bit          wr;
        bit          bad;
        logic [10:0] a;
        int          my_epoch;
        l2_exp_t     e;
        logic [LW-1:0] blk_v;
        bus.l2_ready       = 1'b0;
        bus.l2_block_valid = 1'b0;
        bus.l2_block_in    = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst && (bus.l2_read || bus.l2_write)) begin
                wr = bus.l2_write;
                a  = bus.l2_addr;
                my_epoch = epoch;
                tests++;
                if (l2q.size() == 0) begin
                    fails++;
                    $display("FAIL l2_unexpected: got wr=%0d addr=%h, required no L2 request", wr, a);
                    e.wr = wr; e.addr = a;
                end else begin
                    e = l2q.pop_front();
                    if (e.wr != wr || e.addr !== a) begin
                        fails++;
                        $display("FAIL l2_request: got wr=%0d addr=%h, required wr=%0d addr=%h", wr, a, e.wr, e.addr);
                    end
                end
                if (wr) begin
                    tests++;
                    for (int k = 0; k < BS; k++) begin
                        if (bus.l2_data_out[k*DW +: DW] !== ref_mem[int'(a) + k]) begin
                            fails++;
                            $display("FAIL l2_wdata addr=%h word %0d: got %h, required %h",
                                     a, k, bus.l2_data_out[k*DW +: DW], ref_mem[int'(a) + k]);
                            break;
                        end
                    end
                    for (int k = 0; k < BS; k++) l2mem[int'(a) + k] = bus.l2_data_out[k*DW +: DW];
                end
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                if (my_epoch == epoch) begin
                    bad = !wr && ($urandom_range(0, 3) == 0);
                    if (bad) l2q.push_front(e);
                    for (int k = 0; k < BS; k++) blk_v[k*DW +: DW] = l2mem[int'(a) + k];
                    bus.l2_block_in    = wr ? '0 : blk_v;
                    bus.l2_block_valid = !wr && !bad;
                    bus.l2_ready       = 1'b1;
                    @(posedge clk); #1;
                    bus.l2_ready       = 1'b0;
                    bus.l2_block_valid = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        bit       prev_ready;
        cpu_exp_t e;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.l2_read && bus.l2_write) begin
                tests++; fails++;
                $display("FAIL l2_exclusive: got read=1 write=1, required at most one");
            end
            if (bus.cpu_ready) begin
                tests++;
                if (prev_ready) begin
                    fails++;
                    $display("FAIL ready_pulse: got cpu_ready high two cycles, required one");
                end
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ready: got cpu_ready=1, required no response");
                end else begin
                    e = sb.pop_front();
                    tests++;
                    if (bus.cpu_hit !== e.hit) begin
                        fails++;
                        $display("FAIL cpu_hit: got %b, required %b", bus.cpu_hit, e.hit);
                    end
                    if (!e.wr) begin
                        tests++;
                        if (bus.cpu_rdata !== e.data) begin
                            fails++;
                            $display("FAIL cpu_rdata: got %h, required %h", bus.cpu_rdata, e.data);
                        end
                    end
                end
            end
            prev_ready = bus.cpu_ready;
        end
    end

    initial begin : stim
        int          n;
        logic [10:0] a;
        l2_exp_t     le;
        for (int i = 0; i < 2048; i++) begin
            ref_mem[i] = 32'h0000_0FC0 + 32'(i);
            l2mem[i]   = 32'h0000_0FC0 + 32'(i);
        end
        for (int i = 0; i < 4; i++) resident[i] = -1;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.cpu_ready, bus.cpu_hit, bus.l2_read, bus.l2_write} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 0000",
                     {bus.cpu_ready, bus.cpu_hit, bus.l2_read, bus.l2_write});
        end
        tests++;
        if (bus.cpu_rdata !== '0 || bus.l2_addr !== '0) begin
            fails++;
            $display("FAIL reset_data: got rdata=%h l2_addr=%h, required 0", bus.cpu_rdata, bus.l2_addr);
        end
        tests++;
        if (bus.l2_data_out !== '0) begin
            fails++;
            $display("FAIL reset_line: got nonzero l2_data_out, required 0");
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);

        do_op(1'b0, 11'h040, 32'h0);
        do_op(1'b0, 11'h045, 32'h0);
        do_op(1'b1, 11'h047, 32'hDEADBEEF);
        do_op(1'b0, 11'h047, 32'h0);
        do_op(1'b1, 11'h1A3, 32'h55);
        do_op(1'b0, 11'h040, 32'h0);
        do_op(1'b0, 11'h0C0, 32'h0);
        do_op(1'b0, 11'h040, 32'h0);

        // Reset while a fill is outstanding
        le.wr = 1'b0; le.addr = 11'h140;
        l2q.push_back(le);
        @(posedge clk); #1;
        bus.cpu_addr = 11'h140;
        bus.cpu_read = 1'b1;
        n = 0;
        while (!bus.l2_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!bus.l2_read) begin
            fails++;
            $display("FAIL fill_start: got l2_read=0, required 1");
        end
        rst = 1'b1;
        epoch++;
        #1;
        tests++;
        if ({bus.l2_read, bus.l2_write, bus.cpu_ready, bus.cpu_hit} !== 4'b0 ||
            bus.l2_addr !== '0 || bus.cpu_rdata !== '0 || bus.l2_data_out !== '0) begin
            fails++;
            $display("FAIL abort_outputs: got rd=%b wr=%b ready=%b l2_addr=%h, required all 0",
                     bus.l2_read, bus.l2_write, bus.cpu_ready, bus.l2_addr);
        end
        bus.cpu_read = 1'b0;
        for (int i = 0; i < 4; i++) resident[i] = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        do_op(1'b0, 11'h140, 32'h0);
        do_op(1'b0, 11'h040, 32'h0);

        for (int i = 0; i < 250; i++) begin
            a = {4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
            do_op($urandom_range(0, 2) == 0, a, $urandom);
        end

        repeat (10) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL cpu_pending: got %0d outstanding, required 0", sb.size());
        end
        tests++;
        if (l2q.size() != 0) begin
            fails++;
            $display("FAIL l2_pending: got %0d outstanding, required 0", l2q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/l1_cache.md
# l1_cache

Direct-mapped, write-through, write-allocate L1 data cache that sits between the CPU load/store port and `L2_cache`. It serves single-word CPU reads and writes from a small block store. It fetches whole blocks from L2 on a miss and writes the full updated block through to L2 on every store. It drives the L2 block request interface (`l1_cache_*` on the L2 side) and holds each request until L2 answers.

## Interface
- `DATA_WIDTH`, default 32: word width.
- `ADDR_WIDTH`, default 11: word address width, shared with L2.
- `CACHE_SIZE`, default 128: capacity in words.
- `BLOCK_SIZE`, default 32: words per line; must match L2.
- Derived: `LINES = CACHE_SIZE/BLOCK_SIZE` (4), `OFFSET_W = clog2(BLOCK_SIZE)` (5), `INDEX_W = clog2(LINES)` (2), `TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W` (4).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_addr` in ADDR_WIDTH: word address; held stable while a request is pending.
- `cpu_wdata` in DATA_WIDTH: store data.
- `cpu_read` in 1: load request; held until `cpu_ready`.
- `cpu_write` in 1: store request; held until `cpu_ready`; mutually exclusive with `cpu_read`.
- `cpu_rdata` out DATA_WIDTH: load data; valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_hit` out 1: qualifies `cpu_ready`; 1 = served without an L2 fill.
- `l2_addr` out ADDR_WIDTH: block-aligned address `{tag, index, 0}`.
- `l2_data_out` out BLOCK_SIZE*DATA_WIDTH: full line for L2 writes.
- `l2_read` out 1: block fetch request.
- `l2_write` out 1: block write-through request.
- `l2_block_in` in BLOCK_SIZE*DATA_WIDTH: block returned by L2.
- `l2_block_valid` in 1: `l2_block_in` is valid.
- `l2_ready` in 1: L2 completion pulse.

## Operation
- Storage per line: tag, valid bit, and BLOCK_SIZE words. Reset clears all valid bits; data and tag contents are don't-care.
- Address split: tag = `cpu_addr[ADDR_WIDTH-1 -: TAG_W]`, index = next INDEX_W bits, offset = low OFFSET_W bits.
- FSM states: IDLE, LOOKUP, FILL, WTHRU, RESP.
- IDLE: if `cpu_read|cpu_write`, latch address, write data and operation, then go to LOOKUP.
- LOOKUP: hit = valid[index] && tag match.
  - Read hit: register `cpu_rdata` = line word[offset], set hit flag = 1, go to RESP.
  - Write hit: write `cpu_wdata` into word[offset], set hit flag = 1, go to WTHRU.
  - Miss (either operation): set hit flag = 0, go to FILL. The victim is the indexed line, which is always clean (write-through), so it is overwritten with no writeback.
- FILL: `l2_read`=1, `l2_addr` = block-aligned latched address.
  - On `l2_ready && l2_block_valid`: install the block, tag, and valid=1.
  - Read: `cpu_rdata` = block word[offset], go to RESP.
  - Write: install the block with word[offset] replaced by the latched write data, go to WTHRU.
  - `l2_ready` without `l2_block_valid`: stay in FILL and re-request.
- WTHRU: `l2_write`=1, `l2_addr` = block-aligned address, `l2_data_out` = updated line. On `l2_ready`, go to RESP.
- RESP: `cpu_ready`=1, `cpu_hit` = hit flag, then go to IDLE.
- Request gating: `l2_read` = (state==FILL) && !`l2_ready`, and likewise `l2_write` for WTHRU. These are combinational, so the request drops in the same cycle L2's registered ready arrives, and L2 (then in its IDLE state) does not re-trigger.
- Reset values: all outputs 0 (`cpu_rdata`, `cpu_ready`, `cpu_hit`, `l2_addr`, `l2_data_out`, `l2_read`, `l2_write`); state IDLE.
- Reset during FILL or WTHRU abandons the transaction: no line is installed and no `cpu_ready` is issued.
- `l2_data_out` and `l2_addr` hold stable for the whole of FILL and WTHRU.

## Timing
- Read hit: request seen at edge 0 → LOOKUP → RESP. `cpu_ready`=1 in cycle 2, 3-cycle turnaround including IDLE.
- Write hit: LOOKUP → WTHRU. L2 answers 2 cycles after its request; `cpu_ready` is asserted in the cycle after `l2_ready`.
- Read miss: FILL lasts until L2 responds (≥2 cycles); RESP follows the next cycle.
- Write miss: FILL followed by WTHRU, each ≥2 cycles.
- The CPU must deassert its request on the edge that ends RESP. A new request is accepted in IDLE one cycle later.
- `cpu_ready` never lasts more than one cycle. `l2_read` and `l2_write` are never both 1.

## Test plan
- Cold read 0x040: FILL issues `l2_read` with `l2_addr`=0x040; L2 returns words k=0x1000+k; `cpu_rdata`=0x1000, `cpu_hit`=0.
- Read 0x045 after that fill: no L2 traffic; `cpu_rdata`=0x1005, `cpu_hit`=1, `cpu_ready` in cycle 2.
- Write 0x047←0xDEADBEEF (hit): `l2_write` with `l2_addr`=0x040 and word 7 = 0xDEADBEEF, other words unchanged; a following read of 0x047 hits and returns 0xDEADBEEF.
- Write miss 0x1A3←0x55: FILL of 0x1A0, then WTHRU of the block with word 3 = 0x55; `cpu_hit`=0.
- Conflict: read 0x040, then read 0x0C0 (same index, different tag), then read 0x040 again: the third read misses and refetches.
- Assert `rst` mid-FILL: outputs go to 0 immediately; a following read of the same address misses and no `cpu_ready` is issued for the aborted request.
